// File: rtl/imm_gen_pkg.sv
// Shared types for the immediate-generator pipeline: format codes, RISC-V
// major opcodes and the per-entry metadata kept in the output buffer.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_R    = 3'd1,
    FMT_I    = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6,
    FMT_Z    = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // XLEN-wide immediate and target live in parallel arrays next to this.
  typedef struct packed {
    imm_fmt_e fmt;
    logic     illegal;
  } buf_entry_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decoder: format classification, immediate
// extension to XLEN and pc-relative target for branches, jumps and AUIPC.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic [XLEN-1:0] target,
  output logic            illegal
);

  localparam bit RV64 = (XLEN == 64);

  // Every format is first assembled as a 32-bit signed pattern, then widened.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // Classify the opcode
  always_comb begin
    fmt     = FMT_NONE;
    illegal = 1'b0;
    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (instr[6:0])
        OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM: fmt = FMT_I;
        OPC_OP_IMM_32: begin
          if (RV64) fmt = FMT_I;
          else      illegal = 1'b1;
        end
        OPC_SYSTEM: begin
          if (instr[14]) fmt = FMT_Z;
          else           fmt = FMT_I;
        end
        OPC_STORE:          fmt = FMT_S;
        OPC_BRANCH:         fmt = FMT_B;
        OPC_LUI, OPC_AUIPC: fmt = FMT_U;
        OPC_JAL:            fmt = FMT_J;
        OPC_OP:             fmt = FMT_R;
        OPC_OP_32: begin
          if (RV64) fmt = FMT_R;
          else      illegal = 1'b1;
        end
        default:            illegal = 1'b1;
      endcase
    end
  end

  // Immediate extraction and target
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:   imm = sext32({{20{instr[31]}}, instr[31:20]});
      FMT_S:   imm = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
      FMT_B:   imm = sext32({{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
      FMT_U:   imm = sext32({instr[31:12], 12'b0});
      FMT_J:   imm = sext32({{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});
      FMT_Z:   imm = XLEN'({27'b0, instr[19:15]});
      default: imm = '0;
    endcase
    if (fmt == FMT_B || fmt == FMT_J || (fmt == FMT_U && instr[6:0] == OPC_AUIPC)) begin
      target = pc + imm;
    end else begin
      target = '0;
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a DEPTH-entry output FIFO; decode happens at the
// input and results are presented from the FIFO head one cycle later.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output imm_fmt_e        out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] dec_target;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;

  buf_entry_t      meta_mem [DEPTH];
  logic [XLEN-1:0] imm_mem  [DEPTH];
  logic [XLEN-1:0] tgt_mem  [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          push, pop;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .pc      (in_pc),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .target  (dec_target),
    .illegal (dec_illegal)
  );

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else                     return p + PW'(1);
  endfunction

  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Next pointers and occupancy; flush wins over any accept or pop
  always_comb begin
    count_nxt  = count;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (flush) begin
      count_nxt  = '0;
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      if (push) wr_ptr_nxt = ptr_inc(wr_ptr);
      else      wr_ptr_nxt = wr_ptr;
      if (pop)  rd_ptr_nxt = ptr_inc(rd_ptr);
      else      rd_ptr_nxt = rd_ptr;
      case ({push, pop})
        2'b10:   count_nxt = count + CW'(1);
        2'b01:   count_nxt = count - CW'(1);
        default: count_nxt = count;
      endcase
    end
  end

  // State and storage; in_ready is a register so out_ready never reaches it combinationally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      in_ready <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        meta_mem[i] <= '{fmt: FMT_NONE, illegal: 1'b0};
        imm_mem[i]  <= '0;
        tgt_mem[i]  <= '0;
      end
    end else begin
      count    <= count_nxt;
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      in_ready <= (count_nxt < CW'(DEPTH));
      if (push && !flush) begin
        meta_mem[wr_ptr] <= '{fmt: dec_fmt, illegal: dec_illegal};
        imm_mem[wr_ptr]  <= dec_imm;
        tgt_mem[wr_ptr]  <= dec_target;
      end
    end
  end

  // Head presentation, forced to zero when empty
  always_comb begin
    if (out_valid) begin
      out_imm     = imm_mem[rd_ptr];
      out_fmt     = meta_mem[rd_ptr].fmt;
      out_target  = tgt_mem[rd_ptr];
      out_illegal = meta_mem[rd_ptr].illegal;
    end else begin
      out_imm     = '0;
      out_fmt     = FMT_NONE;
      out_target  = '0;
      out_illegal = 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Drives identical traffic into a 32-bit and a 64-bit imm_gen_pipe and checks
// both every cycle against a queue-based reference built from the ISA rules.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        r32, v32, il32, r64, v64, il64;
  logic [31:0] imm32, tg32;
  logic [63:0] imm64, tg64;
  imm_fmt_e    f32, f64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .DEPTH(2)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r32),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(v32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(f32), .out_target(tg32), .out_illegal(il32));

  imm_gen_pipe #(.XLEN(64), .DEPTH(2)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r64),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(v64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(f64), .out_target(tg64), .out_illegal(il64));

  typedef struct {
    logic [63:0] imm;
    logic [63:0] tgt;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  logic exp_rdy = 1'b0;
  bit   chk_en  = 1'b0;
  int   n_vec   = 0;
  int   n_err   = 0;

  function automatic logic [63:0] sx(input logic [63:0] v, input int n);
    if (v[n-1]) return v - (64'd1 << n);
    else        return v;
  endfunction

  // Reference decode straight from the instruction-set field layouts
  function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc, input int xlen);
    exp_t        r;
    logic [63:0] mask;
    logic        rel;
    mask  = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    r.imm = 64'd0; r.tgt = 64'd0; r.fmt = FMT_NONE; r.ill = 1'b0; rel = 1'b0;
    if (ins[1:0] != 2'b11) r.ill = 1'b1;
    else case (ins[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: begin r.fmt = FMT_I; r.imm = sx(64'(ins[31:20]), 12); end
      7'b0011011: if (xlen == 64) begin r.fmt = FMT_I; r.imm = sx(64'(ins[31:20]), 12); end else r.ill = 1'b1;
      7'b1110011: if (ins[14]) begin r.fmt = FMT_Z; r.imm = 64'(ins[19:15]); end
                  else begin r.fmt = FMT_I; r.imm = sx(64'(ins[31:20]), 12); end
      7'b0100011: begin r.fmt = FMT_S; r.imm = sx(64'(ins[31:25]) * 64'd32 + 64'(ins[11:7]), 12); end
      7'b1100011: begin
        r.fmt = FMT_B; rel = 1'b1;
        r.imm = sx(64'(ins[31]) * 64'd4096 + 64'(ins[7]) * 64'd2048 + 64'(ins[30:25]) * 64'd32 + 64'(ins[11:8]) * 64'd2, 13);
      end
      7'b0110111: begin r.fmt = FMT_U; r.imm = sx(64'(ins[31:12]) * 64'd4096, 32); end
      7'b0010111: begin r.fmt = FMT_U; rel = 1'b1; r.imm = sx(64'(ins[31:12]) * 64'd4096, 32); end
      7'b1101111: begin
        r.fmt = FMT_J; rel = 1'b1;
        r.imm = sx(64'(ins[31]) * 64'd1048576 + 64'(ins[19:12]) * 64'd4096 + 64'(ins[20]) * 64'd2048 + 64'(ins[30:21]) * 64'd2, 21);
      end
      7'b0110011: r.fmt = FMT_R;
      7'b0111011: if (xlen == 64) r.fmt = FMT_R; else r.ill = 1'b1;
      default:    r.ill = 1'b1;
    endcase
    r.imm = r.imm & mask;
    if (rel) r.tgt = (pc + r.imm) & mask;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Reference occupancy: same accept/pop/flush rules applied to queues
  always @(posedge clk) begin
    if (!rst_n) begin
      q32.delete(); q64.delete();
      exp_rdy <= 1'b0;
    end else begin
      if (flush) begin
        q32.delete(); q64.delete();
      end else begin
        if (q32.size() != 0 && out_ready) begin
          void'(q32.pop_front()); void'(q64.pop_front());
        end
        if (in_valid && exp_rdy) begin
          q32.push_back(model(in_instr, in_pc, 32));
          q64.push_back(model(in_instr, in_pc, 64));
        end
      end
      exp_rdy <= (q32.size() < 2);
    end
  end

  // Per-cycle comparison on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready32",  64'(r32), 64'(exp_rdy));
      chk("in_ready64",  64'(r64), 64'(exp_rdy));
      chk("out_valid32", 64'(v32), 64'(q32.size() != 0));
      chk("out_valid64", 64'(v64), 64'(q64.size() != 0));
      chk("imm32",  64'(imm32), (q32.size() != 0) ? q32[0].imm : 64'd0);
      chk("tgt32",  64'(tg32),  (q32.size() != 0) ? q32[0].tgt : 64'd0);
      chk("fmt32",  64'(f32),   (q32.size() != 0) ? 64'(q32[0].fmt) : 64'd0);
      chk("ill32",  64'(il32),  (q32.size() != 0) ? 64'(q32[0].ill) : 64'd0);
      chk("imm64",  imm64,      (q64.size() != 0) ? q64[0].imm : 64'd0);
      chk("tgt64",  tg64,       (q64.size() != 0) ? q64[0].tgt : 64'd0);
      chk("fmt64",  64'(f64),   (q64.size() != 0) ? 64'(q64[0].fmt) : 64'd0);
      chk("ill64",  64'(il64),  (q64.size() != 0) ? 64'(q64[0].ill) : 64'd0);
    end
  end

  task automatic cyc(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                     input logic ordy, input logic fl);
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    @(posedge clk); #1;
  endtask

  logic [31:0] vecs [12] = '{32'hFFF00093, 32'hFE000EE3, 32'h0000101B, 32'h00000010,
                             32'h00001017, 32'hFE112C23, 32'h800000B7, 32'h800000EF,
                             32'h0057D0F3, 32'h00000073, 32'h0000003B, 32'h0000007F};
  exp_t t;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'd0; in_pc = 64'd0;

    // Hand-derived values pinning the reference decode
    t = model(32'hFFF00093, 64'd0, 32);
    chk("pin_addi_imm", t.imm, 64'h0000_0000_FFFF_FFFF);
    chk("pin_addi_fmt", 64'(t.fmt), 64'(FMT_I));
    chk("pin_addi_ill", 64'(t.ill), 64'd0);
    t = model(32'hFE000EE3, 64'h1000, 64);
    chk("pin_beq_imm", t.imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("pin_beq_tgt", t.tgt, 64'h0000_0000_0000_0FFC);
    t = model(32'h0000101B, 64'd0, 32);
    chk("pin_opimm32_ill", 64'(t.ill), 64'd1);
    chk("pin_opimm32_fmt", 64'(t.fmt), 64'(FMT_NONE));
    t = model(32'h00000010, 64'd0, 32);
    chk("pin_low_bits_ill", 64'(t.ill), 64'd1);
    t = model(32'h00001017, 64'hFFFF_FFF0, 32);
    chk("pin_auipc_wrap", t.tgt, 64'h0000_0000_0000_0FF0);

    @(posedge clk); #1;
    chk_en = 1'b1;
    cyc(1'b1, 32'hFFF00093, 64'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(1'b0, 32'd0, 64'd0, 1'b0, 1'b0);

    // Direct literal checks on the DUT outputs one cycle after accept
    cyc(1'b1, 32'hFFF00093, 64'd0, 1'b0, 1'b0);
    chk("dut_addi_imm", 64'(imm32), 64'h0000_0000_FFFF_FFFF);
    chk("dut_addi_fmt", 64'(f32), 64'(FMT_I));
    cyc(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
    cyc(1'b1, 32'hFE000EE3, 64'h1000, 1'b0, 1'b0);
    chk("dut_beq_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("dut_beq_tgt64", tg64, 64'h0000_0000_0000_0FFC);
    cyc(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
    cyc(1'b1, 32'h00001017, 64'hFFFF_FFF0, 1'b0, 1'b0);
    chk("dut_auipc_tgt32", 64'(tg32), 64'h0000_0000_0000_0FF0);
    cyc(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);

    // Back-to-back traffic with a stalling consumer: ordering and pointer wrap
    for (int i = 0; i < 24; i++)
      cyc(1'b1, vecs[i % 12], (i == 7) ? 64'hFFFF_FFFF_FFFF_FFF8 : 64'h8000_0000 + 64'(i) * 64'd4,
          (i % 3) != 0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);

    // Fill to DEPTH, third entry held, then drain in order
    cyc(1'b1, vecs[5], 64'h100, 1'b0, 1'b0);
    cyc(1'b1, vecs[6], 64'h104, 1'b0, 1'b0);
    chk("full_in_ready", 64'(r32), 64'd0);
    cyc(1'b1, vecs[7], 64'h108, 1'b0, 1'b0);
    cyc(1'b1, vecs[7], 64'h108, 1'b0, 1'b0);
    cyc(1'b1, vecs[7], 64'h108, 1'b1, 1'b0);
    cyc(1'b1, vecs[7], 64'h108, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);

    // Flush with a same-cycle input, both at full and at partial occupancy
    cyc(1'b1, vecs[0], 64'h200, 1'b0, 1'b0);
    cyc(1'b1, vecs[1], 64'h204, 1'b0, 1'b0);
    cyc(1'b1, vecs[4], 64'h208, 1'b0, 1'b1);
    chk("flush_full_valid", 64'(v32), 64'd0);
    cyc(1'b1, vecs[8], 64'h20C, 1'b0, 1'b0);
    cyc(1'b1, vecs[9], 64'h210, 1'b1, 1'b1);
    chk("flush_part_valid", 64'(v64), 64'd0);
    cyc(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);

    // Reset mid-stream
    cyc(1'b1, vecs[1], 64'h300, 1'b0, 1'b0);
    cyc(1'b1, vecs[7], 64'h304, 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc(1'b1, vecs[0], 64'h308, 1'b1, 1'b0);
    chk("rst_valid", 64'(v32), 64'd0);
    chk("rst_ready", 64'(r32), 64'd0);
    rst_n = 1'b1;
    cyc(1'b0, 32'd0, 64'd0, 1'b0, 1'b0);
    chk("post_rst_ready", 64'(r32), 64'd1);
    cyc(1'b1, vecs[8], 64'h400, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
